// File: rtl/mgnt_bus_arbiter.sv
// Round-robin arbiter sharing the management command/data channel between
// NUM_MST masters. One whole transaction is granted at a time; a watchdog
// aborts a transaction whose endpoint never acknowledges.
module mgnt_bus_arbiter #(
  parameter int NUM_MST   = 2,
  parameter int TIMEOUT   = 1024,
  parameter int ERR_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MST*8-1:0]   m_req_valid,
  input  logic [NUM_MST-1:0]     m_req_wr,
  input  logic [NUM_MST*8-1:0]   m_req_addr,
  input  logic [NUM_MST*8-1:0]   m_req_data,
  input  logic [NUM_MST-1:0]     m_req_data_valid,
  output logic [NUM_MST-1:0]     m_req_ack,
  output logic [NUM_MST-1:0]     m_req_err,
  output logic [7:0]             m_resp_data,
  output logic [NUM_MST-1:0]     m_resp_data_valid,
  output logic [7:0]             sys_req_valid,
  output logic                   sys_req_wr,
  output logic [7:0]             sys_req_addr,
  output logic [7:0]             sys_req_data,
  output logic                   sys_req_data_valid,
  input  logic                   sys_req_ack,
  input  logic [7:0]             sys_resp_data,
  input  logic                   sys_resp_data_valid,
  output logic                   busy,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam int GW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_BUSY = 3'b010;
  localparam logic [2:0] S_GAP  = 3'b100;

  localparam logic [GW:0]   NM       = (GW+1)'(NUM_MST);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_MST - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  logic [2:0]           state_q, state_d;
  logic [GW-1:0]        gnt_q, gnt_d;
  logic [GW-1:0]        rr_q, rr_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Per-master views of the flattened request buses.
  logic [NUM_MST-1:0][7:0] valid_a, addr_a, data_a;
  logic [NUM_MST-1:0]      req;

  assign valid_a = m_req_valid;
  assign addr_a  = m_req_addr;
  assign data_a  = m_req_data;

  // A master requests whenever any target-select bit is set.
  always_comb begin
    req = '0;
    for (int k = 0; k < NUM_MST; k++) req[k] = |valid_a[k];
  end

  // Completion events for the granted master. A dropped request (abort)
  // takes priority and yields no ack; a real ack beats a same-cycle timeout.
  logic in_busy, gnt_req, abort_ev, ack_ev, tmo_ev;

  assign in_busy  = (state_q == S_BUSY);
  assign gnt_req  = req[gnt_q];
  assign abort_ev = in_busy && !gnt_req;
  assign ack_ev   = in_busy && gnt_req && sys_req_ack;
  assign tmo_ev   = in_busy && gnt_req && !sys_req_ack && (timer_q == T_LAST);

  // Next-state: round-robin pick in IDLE, watchdog in BUSY, pointer advance in GAP.
  logic        found;
  logic [GW:0] cand;
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    timer_d   = timer_q;
    err_cnt_d = err_cnt_q;
    found     = 1'b0;
    cand      = '0;
    case (state_q)
      S_IDLE: begin
        for (int i = 0; i < NUM_MST; i++) begin
          cand = {1'b0, rr_q} + (GW+1)'(i);
          if (cand >= NM) cand = cand - NM;
          if (!found && req[cand[GW-1:0]]) begin
            found = 1'b1;
            gnt_d = cand[GW-1:0];
          end
        end
        if (found) begin
          timer_d = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        timer_d = timer_q + 1'b1;
        if (abort_ev || ack_ev) begin
          state_d = S_GAP;
        end else if (tmo_ev) begin
          state_d = S_GAP;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        rr_d    = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output muxing: only BUSY drives the channel; a timeout cycle kills the strobes.
  always_comb begin
    sys_req_valid      = '0;
    sys_req_wr         = 1'b0;
    sys_req_addr       = '0;
    sys_req_data       = '0;
    sys_req_data_valid = 1'b0;
    m_resp_data        = '0;
    m_resp_data_valid  = '0;
    m_req_ack          = '0;
    m_req_err          = '0;
    if (in_busy) begin
      sys_req_valid      = tmo_ev ? 8'h00 : valid_a[gnt_q];
      sys_req_wr         = m_req_wr[gnt_q];
      sys_req_addr       = addr_a[gnt_q];
      sys_req_data       = data_a[gnt_q];
      sys_req_data_valid = tmo_ev ? 1'b0 : m_req_data_valid[gnt_q];
      m_resp_data              = sys_resp_data;
      m_resp_data_valid[gnt_q] = sys_resp_data_valid;
      m_req_ack[gnt_q]         = ack_ev || tmo_ev;
      m_req_err[gnt_q]         = tmo_ev;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign err_cnt = err_cnt_q;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      rr_q      <= '0;
      timer_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule
